// File: rtl/pipelined_barrel_shifter.sv
// ============================================================================
// Module   : pipelined_barrel_shifter
// Brief    : Granular rotate/shift unit with a configurable register cadence
//            and a valid/ready stream handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipelined_barrel_shifter #(
    parameter int WIDTH              = 32,
    parameter int SHIFTBITS_PER_STEP = 1,
    parameter int STAGES_PER_REG     = 1,
    parameter int TAG_WIDTH          = 4
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [WIDTH-1:0]                             in_data,
    input  logic [$clog2(WIDTH/SHIFTBITS_PER_STEP)-1:0]  in_amount,
    input  logic [1:0]                                   in_mode,
    input  logic [TAG_WIDTH-1:0]                         in_tag,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [WIDTH-1:0]                             out_data,
    output logic [TAG_WIDTH-1:0]                         out_tag
);

    localparam int c_AMT_BITS = $clog2(WIDTH / SHIFTBITS_PER_STEP);
    localparam int c_STAGES   = c_AMT_BITS;
    localparam int c_SPR      = (STAGES_PER_REG == 0) ? 1 : STAGES_PER_REG;
    localparam int c_LAT      = (STAGES_PER_REG == 0) ? 0 :
                                (c_STAGES + STAGES_PER_REG - 1) / STAGES_PER_REG;

    function automatic logic [WIDTH-1:0] bitReverse(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int b = 0; b < WIDTH; b++) begin
            r[b] = x[WIDTH-1-b];
        end
        return r;
    endfunction

    logic [WIDTH-1:0]      w_data   [0:c_STAGES];
    logic                  w_valid  [0:c_STAGES];
    logic [TAG_WIDTH-1:0]  w_tag    [0:c_STAGES];
    logic [1:0]            w_mode   [0:c_STAGES];
    logic [c_AMT_BITS-1:0] w_amount [0:c_STAGES-1];
    logic                  w_sign   [0:c_STAGES-1];
    logic                  w_advance;

    // Rotate-left reuses the right-rotate network between two bit reversals.
    assign w_data[0]   = (in_mode == 2'b01) ? bitReverse(in_data) : in_data;
    assign w_valid[0]  = in_valid;
    assign w_tag[0]    = in_tag;
    assign w_mode[0]   = in_mode;
    assign w_amount[0] = in_amount;
    assign w_sign[0]   = in_data[WIDTH-1];

    for (genvar i = 0; i < c_STAGES; i++) begin : g_stage
        localparam int c_SHIFT = (2 ** i) * SHIFTBITS_PER_STEP;
        localparam bit c_REG   = (STAGES_PER_REG != 0) &&
                                 ((((i + 1) % c_SPR) == 0) || (i == c_STAGES - 1));

        logic [WIDTH-1:0] w_shifted;
        logic             w_fill;

        always_comb begin
            w_fill    = w_mode[i][0] & w_sign[i];
            w_shifted = w_data[i];
            if (w_amount[i][i]) begin
                if (w_mode[i][1]) begin
                    w_shifted = {{c_SHIFT{w_fill}}, w_data[i][WIDTH-1:c_SHIFT]};
                end else begin
                    w_shifted = {w_data[i][c_SHIFT-1:0], w_data[i][WIDTH-1:c_SHIFT]};
                end
            end
        end

        if (c_REG) begin : g_reg
            logic [WIDTH-1:0]     r_data;
            logic                 r_valid;
            logic [TAG_WIDTH-1:0] r_tag;
            logic [1:0]           r_mode;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                    r_tag   <= '0;
                    r_mode  <= 2'b00;
                end else if (w_advance) begin
                    r_data  <= w_shifted;
                    r_valid <= w_valid[i];
                    r_tag   <= w_tag[i];
                    r_mode  <= w_mode[i];
                end
            end

            assign w_data[i+1]  = r_data;
            assign w_valid[i+1] = r_valid;
            assign w_tag[i+1]   = r_tag;
            assign w_mode[i+1]  = r_mode;

            // Amount and sign are only needed by the stages still ahead.
            if (i < c_STAGES - 1) begin : g_carry
                logic [c_AMT_BITS-1:0] r_amount;
                logic                  r_sign;

                always_ff @(posedge clk) begin
                    if (!reset_n) begin
                        r_amount <= '0;
                        r_sign   <= 1'b0;
                    end else if (w_advance) begin
                        r_amount <= w_amount[i];
                        r_sign   <= w_sign[i];
                    end
                end

                assign w_amount[i+1] = r_amount;
                assign w_sign[i+1]   = r_sign;
            end
        end else begin : g_comb
            assign w_data[i+1]  = w_shifted;
            assign w_valid[i+1] = w_valid[i];
            assign w_tag[i+1]   = w_tag[i];
            assign w_mode[i+1]  = w_mode[i];

            if (i < c_STAGES - 1) begin : g_carry
                assign w_amount[i+1] = w_amount[i];
                assign w_sign[i+1]   = w_sign[i];
            end
        end
    end

    assign out_valid = w_valid[c_STAGES];
    assign out_tag   = w_tag[c_STAGES];
    assign out_data  = (w_mode[c_STAGES] == 2'b01) ? bitReverse(w_data[c_STAGES])
                                                   : w_data[c_STAGES];

    if (c_LAT == 0) begin : g_ready_comb
        assign in_ready = out_ready;
    end else begin : g_ready_pipe
        assign in_ready = out_ready | ~out_valid;
    end

    assign w_advance = in_ready;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
// ============================================================================
// Module   : tb_pipelined_barrel_shifter
// Brief    : Directed and random stream checks of the barrel shifter against
//            an arithmetic reference model and a beat scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_barrel_shifter;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetN;
    logic        inValid, inReady, outValid, outReady;
    logic [31:0] inData, outData;
    logic [4:0]  inAmount;
    logic [1:0]  inMode;
    logic [3:0]  inTag, outTag;

    logic        b8Valid, b8OutReady;
    logic [31:0] b8Data;
    logic [1:0]  b8Amount, b8Mode;
    logic [3:0]  b8Tag;
    logic        r8InReady, r8Valid, c8InReady, c8Valid;
    logic [31:0] r8Data, c8Data;
    logic [3:0]  r8Tag, c8Tag;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[$];
    bit   checkLat = 1'b0;
    bit   prevStall = 1'b0;
    logic [31:0] prevData;
    logic [3:0]  prevTag;

    always #5 clk = ~clk;

    pipelined_barrel_shifter #(.WIDTH(32), .SHIFTBITS_PER_STEP(1), .STAGES_PER_REG(2), .TAG_WIDTH(4)) dut (
        .clk(clk), .reset_n(resetN), .in_valid(inValid), .in_ready(inReady),
        .in_data(inData), .in_amount(inAmount), .in_mode(inMode), .in_tag(inTag),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData), .out_tag(outTag)
    );

    pipelined_barrel_shifter #(.WIDTH(32), .SHIFTBITS_PER_STEP(8), .STAGES_PER_REG(2), .TAG_WIDTH(4)) dut8r (
        .clk(clk), .reset_n(resetN), .in_valid(b8Valid), .in_ready(r8InReady),
        .in_data(b8Data), .in_amount(b8Amount), .in_mode(b8Mode), .in_tag(b8Tag),
        .out_valid(r8Valid), .out_ready(b8OutReady), .out_data(r8Data), .out_tag(r8Tag)
    );

    pipelined_barrel_shifter #(.WIDTH(32), .SHIFTBITS_PER_STEP(8), .STAGES_PER_REG(0), .TAG_WIDTH(4)) dut8c (
        .clk(clk), .reset_n(resetN), .in_valid(b8Valid), .in_ready(c8InReady),
        .in_data(b8Data), .in_amount(b8Amount), .in_mode(b8Mode), .in_tag(b8Tag),
        .out_valid(c8Valid), .out_ready(b8OutReady), .out_data(c8Data), .out_tag(c8Tag)
    );

    // Reference: shift distance k in bits, computed with plain wide arithmetic.
    function automatic logic [31:0] model(input logic [31:0] d, input int k, input logic [1:0] m);
        logic [63:0] dd;
        dd = {d, d};
        case (m)
            2'b00:   return 32'(dd >> k);
            2'b01:   return 32'((dd << k) >> 32);
            2'b10:   return d >> k;
            default: return 32'($signed(d) >>> k);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock cycle on the main DUT: drive, check the output beat, score the input beat.
    task automatic step(input bit v, input logic [31:0] d, input logic [4:0] a, input logic [1:0] m,
                        input logic [3:0] t, input bit ordy, input logic [31:0] e);
        exp_t it;
        inValid  = v;
        inData   = d;
        inAmount = a;
        inMode   = m;
        inTag    = t;
        outReady = ordy;
        #1;
        if (prevStall) begin
            chk("stall_data", outData, prevData);
            chk("stall_tag", outTag, prevTag);
        end
        if (outValid && !ordy) chk("stall_in_ready", inReady, 0);
        if (outValid && ordy) begin
            if (q.size() == 0) begin
                chk("spurious_beat", outValid, 0);
            end else begin
                it = q.pop_front();
                chk("out_data", outData, it.d);
                chk("out_tag", outTag, it.t);
                if (checkLat) chk("latency", cyc - it.c, 3);
            end
        end
        if (v && inReady) begin
            it.d = e;
            it.t = t;
            it.c = cyc;
            q.push_back(it);
        end
        prevStall = outValid && !ordy;
        prevData  = outData;
        prevTag   = outTag;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 5'd0, 2'b00, 4'h0, 1'b1, 32'h0);
    endtask

    task automatic randStep(input bit ordy);
        logic [31:0] d;
        logic [4:0]  a;
        logic [1:0]  m;
        logic [3:0]  t;
        d = $urandom;
        a = 5'($urandom_range(0, 31));
        m = 2'($urandom_range(0, 3));
        t = 4'($urandom_range(0, 15));
        step(($urandom % 4) != 0, d, a, m, t, ordy, model(d, int'(a), m));
    endtask

    initial begin
        resetN = 1'b0;
        inValid = 1'b0; inData = '0; inAmount = '0; inMode = '0; inTag = '0; outReady = 1'b1;
        b8Valid = 1'b0; b8Data = '0; b8Amount = '0; b8Mode = '0; b8Tag = '0; b8OutReady = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_out_valid", outValid, 0);
        chk("reset_out_data", outData, 0);
        chk("reset_out_tag", outTag, 0);
        chk("reset_in_ready", inReady, 1);
        chk("reset_r8_valid", r8Valid, 0);
        resetN = 1'b1;

        // Directed single beats with exact latency
        checkLat = 1'b1;
        step(1'b1, 32'h80000001, 5'd1, 2'b00, 4'hA, 1'b1, 32'hC0000000);
        drain(4);
        step(1'b1, 32'h80000001, 5'd4,  2'b01, 4'h1, 1'b1, 32'h00000018);
        step(1'b1, 32'hF0000000, 5'd31, 2'b10, 4'h2, 1'b1, 32'h00000001);
        step(1'b1, 32'h80000000, 5'd31, 2'b11, 4'h3, 1'b1, 32'hFFFFFFFF);
        step(1'b1, 32'h40000000, 5'd30, 2'b11, 4'h4, 1'b1, 32'h00000001);
        step(1'b1, 32'h12345678, 5'd0,  2'b11, 4'h5, 1'b1, 32'h12345678);
        step(1'b1, 32'h12345678, 5'd0,  2'b01, 4'h6, 1'b1, 32'h12345678);

        // Back-to-back stream, amounts and tags 0..7
        for (int k = 0; k < 8; k++)
            step(1'b1, 32'hA5C30F01, 5'(k), 2'b00, 4'(k), 1'b1, model(32'hA5C30F01, k, 2'b00));
        drain(5);
        chk("stream_drained", q.size(), 0);

        // Backpressure for five cycles mid-stream
        checkLat = 1'b0;
        for (int k = 0; k < 12; k++)
            step(1'b1, 32'h0F0F1234 + 32'(k), 5'(k + 3), 2'(k), 4'(k), !(k >= 4 && k < 9),
                 model(32'h0F0F1234 + 32'(k), k + 3, 2'(k)));
        drain(8);
        chk("stall_drained", q.size(), 0);

        // Reset with three beats in flight
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'hDEADBEEF, 5'(k + 1), 2'b00, 4'(k + 8), 1'b1, model(32'hDEADBEEF, k + 1, 2'b00));
        resetN = 1'b0;
        inValid = 1'b0;
        outReady = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        resetN = 1'b1;
        q.delete();
        prevStall = 1'b0;
        #1;
        chk("midreset_out_valid", outValid, 0);
        chk("midreset_out_data", outData, 0);
        chk("midreset_out_tag", outTag, 0);
        drain(6);

        // Random traffic, first with free-flowing output, then random backpressure
        checkLat = 1'b1;
        for (int k = 0; k < 150; k++) randStep(1'b1);
        drain(5);
        checkLat = 1'b0;
        for (int k = 0; k < 150; k++) randStep(($urandom % 3) != 0);
        drain(10);
        chk("random_drained", q.size(), 0);

        // Byte-granular variants: one register stage and fully combinational
        b8Valid = 1'b1; b8Data = 32'h11223344; b8Amount = 2'd3; b8Mode = 2'b00; b8Tag = 4'h5;
        #1;
        chk("comb8_valid", c8Valid, 1);
        chk("comb8_data", c8Data, 32'h22334411);
        chk("comb8_tag", c8Tag, 4'h5);
        chk("comb8_in_ready", c8InReady, 1);
        b8Mode = 2'b11; b8Data = 32'h80FF0000; b8Amount = 2'd2;
        #1;
        chk("comb8_asr", c8Data, model(32'h80FF0000, 16, 2'b11));
        b8Mode = 2'b00; b8Data = 32'h11223344; b8Amount = 2'd3;
        @(posedge clk);
        @(negedge clk);
        b8Valid = 1'b0;
        #1;
        chk("reg8_valid", r8Valid, 1);
        chk("reg8_data", r8Data, 32'h22334411);
        chk("reg8_tag", r8Tag, 4'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
